// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int unsigned WB_DATA_W = 8;
    localparam int unsigned WB_ADDR_W = 3;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-requester write-back FIFO; exposes every slot's dest and valid bit
// so the top can build the register pending mask.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output wb_entry_t                  head,
    output logic [DEPTH*WB_ADDR_W-1:0] dests,
    output logic [DEPTH-1:0]           valids
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_offs;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_offs = '0;
        valids = '0;
        dests  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_offs    = PTR_W'(i) - r_rd_ptr;
            valids[i] = (CNT_W'(w_offs) < r_count);
            dests[i*WB_ADDR_W +: WB_ADDR_W] = r_mem[i].dest;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load write-backs onto the single register-file write port.
// Optional build macro WB_FIXED_PRIO_EN: load return always wins on contention.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_W-1:0]    req0_dest,
    input  logic [DATA_W-1:0]    req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_W-1:0]    req1_dest,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 reg_write_en,
    output logic [ADDR_W-1:0]    reg_write_dest,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic [2**ADDR_W-1:0] pending_mask,
    output logic                 busy
);

    wb_entry_t                    w_in0, w_in1, w_head0, w_head1, w_sel;
    logic                         w_full0, w_full1, w_empty0, w_empty1;
    logic                         w_push0, w_push1, w_pop0, w_pop1;
    logic [FIFO_DEPTH*ADDR_W-1:0] w_dests0, w_dests1;
    logic [FIFO_DEPTH-1:0]        w_valids0, w_valids1;
    logic [2**ADDR_W-1:0]         w_mask;

    logic                         r_wr_en;
    logic [ADDR_W-1:0]            r_wr_dest;
    logic [DATA_W-1:0]            r_wr_data;

    assign w_in0      = '{dest: req0_dest, data: req0_data};
    assign w_in1      = '{dest: req1_dest, data: req1_data};
    assign req0_ready = ~w_full0;
    assign req1_ready = ~w_full1;
    assign w_push0    = req0_valid & ~w_full0;
    assign w_push1    = req1_valid & ~w_full1;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_alu (
        .clk(clk), .rst(rst), .push(w_push0), .push_entry(w_in0), .pop(w_pop0),
        .full(w_full0), .empty(w_empty0), .head(w_head0),
        .dests(w_dests0), .valids(w_valids0)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_load (
        .clk(clk), .rst(rst), .push(w_push1), .push_entry(w_in1), .pop(w_pop1),
        .full(w_full1), .empty(w_empty1), .head(w_head1),
        .dests(w_dests1), .valids(w_valids1)
    );

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        w_pop1 = ~w_empty1;
        w_pop0 = ~w_empty0 & w_empty1;
        w_sel  = w_pop1 ? w_head1 : w_head0;
    end
`else
    logic r_rr;

    always_comb begin
        w_pop0 = 1'b0;
        w_pop1 = 1'b0;
        if (!w_empty0 && !w_empty1) begin
            w_pop0 = (r_rr == 1'(REQ_ALU));
            w_pop1 = ~w_pop0;
        end else begin
            w_pop0 = ~w_empty0;
            w_pop1 = ~w_empty1;
        end
        w_sel = w_pop1 ? w_head1 : w_head0;
    end

    // Pointer only moves on contention; one-sided pops leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'(REQ_ALU);
        end else if (!w_empty0 && !w_empty1) begin
            r_rr <= ~r_rr;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_dest <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (w_pop0 | w_pop1) && (w_sel.dest != '0);
            if (w_pop0 | w_pop1) begin
                r_wr_dest <= w_sel.dest;
                r_wr_data <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (w_valids0[i]) w_mask[w_dests0[i*ADDR_W +: ADDR_W]] = 1'b1;
            if (w_valids1[i]) w_mask[w_dests1[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (r_wr_en) w_mask[r_wr_dest] = 1'b1;
        w_mask[0] = 1'b0;
    end

    assign pending_mask   = w_mask;
    assign busy           = ~w_empty0 | ~w_empty1 | r_wr_en;
    assign reg_write_en   = r_wr_en;
    assign reg_write_dest = r_wr_dest;
    assign reg_write_data = r_wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random stimulus against a queue-based write-back model.
module tb_regfile_wb_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_dest, req1_dest;
    logic [DW-1:0] req0_data, req1_data;
    logic          reg_write_en;
    logic [AW-1:0] reg_write_dest;
    logic [DW-1:0] reg_write_data;
    logic [7:0]    pending_mask;
    logic          busy;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dest(req0_dest), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dest(req1_dest), .req1_data(req1_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .pending_mask(pending_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int dest; int data; } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int   m_rr, m_en, m_dest, m_data;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        foreach (q0[i]) if (q0[i].dest != 0) m[q0[i].dest] = 1'b1;
        foreach (q1[i]) if (q1[i].dest != 0) m[q1[i].dest] = 1'b1;
        if (m_en != 0) m[m_dest] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_rr = 0; m_en = 0; m_dest = 0; m_data = 0;
    endtask

    // Inputs are stable across the edge, so the model reads them directly.
    task automatic model_edge();
        bit   rdy0, rdy1, pop0, pop1;
        ent_t e;
        rdy0 = (q0.size() < DEPTH);
        rdy1 = (q1.size() < DEPTH);
        pop0 = 0; pop1 = 0;
        if (q0.size() != 0 && q1.size() != 0) begin
`ifdef WB_FIXED_PRIO_EN
            pop1 = 1;
`else
            if (m_rr == 0) pop0 = 1; else pop1 = 1;
            m_rr = 1 - m_rr;
`endif
        end else if (q0.size() != 0) pop0 = 1;
        else if (q1.size() != 0) pop1 = 1;
        if (pop0 || pop1) begin
            e = pop0 ? q0.pop_front() : q1.pop_front();
            m_en = (e.dest != 0) ? 1 : 0;
            m_dest = e.dest; m_data = e.data;
        end else m_en = 0;
        if (req0_valid && rdy0) q0.push_back('{int'(req0_dest), int'(req0_data)});
        if (req1_valid && rdy1) q1.push_back('{int'(req1_dest), int'(req1_data)});
    endtask

    task automatic check_outputs();
        chk("req0_ready", 32'(req0_ready), 32'(q0.size() < DEPTH));
        chk("req1_ready", 32'(req1_ready), 32'(q1.size() < DEPTH));
        chk("reg_write_en", 32'(reg_write_en), 32'(m_en));
        if (m_en != 0) begin
            chk("reg_write_dest", 32'(reg_write_dest), 32'(m_dest));
            chk("reg_write_data", 32'(reg_write_data), 32'(m_data));
        end
        chk("pending_mask", 32'(pending_mask), 32'(model_mask()));
        chk("busy", 32'(busy), 32'(q0.size() != 0 || q1.size() != 0 || m_en != 0));
    endtask

    task automatic cycle(input int v0, input int d0, input int a0,
                         input int v1, input int d1, input int a1);
        req0_valid = 1'(v0); req0_dest = AW'(d0); req0_data = DW'(a0);
        req1_valid = 1'(v1); req1_dest = AW'(d1); req1_data = DW'(a1);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_dest = 3'd5; req0_data = 8'h11;
        req1_valid = 1'b1; req1_dest = 3'd6; req1_data = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_dest", 32'(reg_write_dest), 32'h0);
        chk("reset_data", 32'(reg_write_data), 32'h0);
        rst = 1'b0;
        #1;
        check_outputs();
        cycle(1, 5, 8'h11, 1, 6, 8'h22);
        chk("no_write_before_pop", 32'(reg_write_en), 32'h0);
        idle(4);

        // single write with fixed latency
        cycle(1, 3, 8'hA5, 0, 0, 0);
        chk("single_mask3_pushed", 32'(pending_mask[3]), 32'h1);
        chk("single_en_pushed", 32'(reg_write_en), 32'h0);
        idle(1);
        chk("single_en", 32'(reg_write_en), 32'h1);
        chk("single_dest", 32'(reg_write_dest), 32'h3);
        chk("single_data", 32'(reg_write_data), 32'hA5);
        chk("single_mask3_out", 32'(pending_mask[3]), 32'h1);
        idle(1);
        chk("single_mask_clear", 32'(pending_mask), 32'h0);

        // contention and back-pressure: both requesters push every cycle
        for (int k = 0; k < 10; k++) cycle(1, 1, $urandom, 1, 2, 8'h40 + k);
        idle(6);

        // register 0 write is dropped but takes its slot
        cycle(1, 0, 8'hFF, 0, 0, 0);
        cycle(1, 4, 8'h3C, 0, 0, 0);
        chk("r0_en_low", 32'(reg_write_en), 32'h0);
        chk("r0_mask_bit0", 32'(pending_mask[0]), 32'h0);
        idle(1);
        chk("r0_next_dest", 32'(reg_write_dest), 32'h4);
        idle(2);

        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom,
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom);
        idle(6);

        // reset mid-stream with three entries queued
        cycle(1, 2, 8'h10, 1, 3, 8'h20);
        cycle(1, 4, 8'h30, 1, 5, 8'h40);
        chk("queued_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: requester 0 is the ALU result, requester 1 is the memory-load return.
- Each requester has a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs one entry per cycle onto the register file's write-enable/dest/data inputs.
- Sits between the execute/memory stages and the register file. It also exports a per-register pending mask that the issue logic uses for hazard stalls.

Parameters:
- DATA_W, 8, width of write data
- ADDR_W, 3, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 FIFO not full
- req0_dest  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid  in  1  requester 1 has a write
- req1_ready  out  1  requester 1 FIFO not full
- req1_dest  in  ADDR_W  requester 1 destination register
- req1_data  in  DATA_W  requester 1 write data
- reg_write_en  out  1  register file write enable (registered)
- reg_write_dest  out  ADDR_W  register file write address (registered)
- reg_write_data  out  DATA_W  register file write data (registered)
- pending_mask  out  2**ADDR_W  bit r set while any queued or output-stage write targets register r
- busy  out  1  any FIFO non-empty or reg_write_en high

Behaviour:
- Reset (async assert, sync release):
  - FIFOs emptied; rr pointer = 0 (requester 0 favoured first).
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0; pending_mask=0, busy=0.
  - Reset asserted mid-operation discards all queued writes; nothing reaches the register file.
- Handshake:
  - Push occurs on a posedge with reqN_valid & reqN_ready.
  - reqN_ready = !fullN; it does not depend on a same-cycle pop, so a full FIFO never accepts.
  - dest and data are sampled only on a push.
  - valid may drop without a push.
- Arbitration, evaluated each cycle on FIFO head entries:
  - Exactly one FIFO non-empty: pop that FIFO.
  - Both FIFOs non-empty: pop the FIFO selected by rr, then set rr to the other requester.
  - One-sided pops leave rr unchanged.
  - Neither FIFO non-empty: no pop; reg_write_en=0 next cycle.
- Output stage:
  - The popped entry is registered onto reg_write_* at the same posedge as the pop.
  - reg_write_en=1 for exactly one cycle per popped entry; the register file captures it on the following negedge.
  - Minimum latency: push at edge N, pop at edge N+1, write visible during cycle N+1.
  - Throughput: one write per cycle total.
- Register 0 is hardwired to zero. An entry with dest==0 is popped and consumes its arbitration slot, but reg_write_en stays 0 for that cycle.
- Ordering:
  - Strict FIFO order within a requester.
  - Across requesters, order is the arbitration order. Two writes to the same register land in that order and the later one wins.
- pending_mask:
  - Combinational OR of one-hot(dest) over all valid FIFO entries plus the output stage while reg_write_en=1.
  - dest==0 entries never set bit 0.
- FIFO pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.

Optional Feature:
- WB_FIXED_PRIO_EN defined:
  - rr pointer is removed; requester 1 (load return) always wins when both FIFOs are non-empty.
  - Requester 0 can starve; this is accepted because load returns are bounded.
- WB_FIXED_PRIO_EN undefined: round-robin as above.

Decomposition:
- Package regfile_wb_pkg holds:
  - DATA_W and ADDR_W defaults;
  - wb_entry_t struct {dest, data};
  - the requester index constants REQ_ALU=0 and REQ_LOAD=1.
- Sub-module wb_fifo, instantiated twice:
  - parameterised depth, storing wb_entry_t;
  - ports push, pop, full, empty, head, and a flat vector of entry dests with valid bits for pending_mask.

Test Plan:
- Reset: hold rst with valid=1 on both requesters; release -> all outputs 0, pending_mask=0, both readies 1, and no write until the cycle after the first accepted push.
- Single write: req0 push dest=3, data=8'hA5 at edge N -> reg_write_en=1, dest=3, data=8'hA5 during cycle N+1; pending_mask bit3 set from N until cycle N+1 ends.
- Contention: both requesters push every cycle (req0 dest=1, req1 dest=2) -> writes alternate dest 1,2,1,2 starting with 1. With WB_FIXED_PRIO_EN, all req1 writes drain first.
- Back-pressure: push 2 entries on req1 while req0 holds the port -> req1_ready=0 after the second push. A third valid is not accepted until a pop frees a slot, and no data is lost or duplicated.
- r0 drop: push dest=0, data=8'hFF -> reg_write_en stays 0 in its slot; pending_mask bit0 never set; the next queued write follows one cycle later.
- Reset mid-stream: assert rst with 3 entries queued -> reg_write_en falls immediately (async), FIFOs empty, and no queued write appears after release.
